// File: rtl/weight_b_loader_pkg.sv
// Shared constants and FSM state type for the weight-B memory loader.
package weight_load_pkg;

  localparam int IN_WIDTH   = 16;
  localparam int BEATS      = 9;
  localparam int DATA_WIDTH = 144;
  localparam int ADDR_WIDTH = 8;
  localparam int BEAT_W     = 4;
  localparam int CNT_W      = ADDR_WIDTH + 1;
  localparam int ACC_WIDTH  = DATA_WIDTH - IN_WIDTH;

  // Packed RAM word must be exactly BEATS input beats wide.
  localparam bit WIDTHS_OK = (DATA_WIDTH == IN_WIDTH * BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/weight_b_loader_if.sv
// Beat stream in, RAM write port out; slave is the loader view, master the host/RAM view.
interface weight_b_loader_if;
  import weight_load_pkg::*;

  logic [IN_WIDTH-1:0]   in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/weight_b_loader_pack_sreg.sv
// Beat-indexed packer: collects BEATS beats and publishes the full word (held until the next one)
// with a one-cycle word_full strobe.
module weight_pack_sreg
  import weight_load_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [BEAT_W-1:0]     beat_idx,
  input  logic [IN_WIDTH-1:0]   beat_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);

  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(BEATS - 1);

  logic [ACC_WIDTH-1:0]  acc_r;
  logic [DATA_WIDTH-1:0] word_r;
  logic                  word_full_r;

  // Partial beats accumulate in acc_r; the final beat is merged straight into the output word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r       <= {ACC_WIDTH{1'b0}};
      word_r      <= {DATA_WIDTH{1'b0}};
      word_full_r <= 1'b0;
    end else if (clear) begin
      acc_r       <= {ACC_WIDTH{1'b0}};
      word_full_r <= 1'b0;
    end else begin
      word_full_r <= 1'b0;
      if (load) begin
        for (int k = 0; k < BEATS - 1; k++) begin
          if (beat_idx == BEAT_W'(k)) begin
            acc_r[k*IN_WIDTH +: IN_WIDTH] <= beat_data;
          end else begin
            acc_r[k*IN_WIDTH +: IN_WIDTH] <= acc_r[k*IN_WIDTH +: IN_WIDTH];
          end
        end
        if (beat_idx == LAST_IDX) begin
          word_r      <= {beat_data, acc_r};
          word_full_r <= 1'b1;
        end else begin
          word_r <= word_r;
        end
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  assign word      = word_r;
  assign word_full = word_full_r;

endmodule

// File: rtl/weight_b_loader.sv
// Streaming writer for the weight-B RAM: packs nine 16-bit beats per 144-bit word and writes
// words to consecutive addresses from 0.
module weight_b_loader
  import weight_load_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] num_words,
  weight_b_loader_if.slave    bus,
  output logic                busy,
  output logic                done
);

  if (!WIDTHS_OK) begin : g_width_check
    $error("weight_b_loader: DATA_WIDTH must equal IN_WIDTH * BEATS");
  end

  state_t                state_r;
  logic                  in_ready_r;
  logic                  busy_r;
  logic                  done_r;
  logic [CNT_W-1:0]      num_r;
  logic [CNT_W-1:0]      word_cnt_r;
  logic [BEAT_W-1:0]     beat_cnt_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;

  logic                  beat_fire_s;
  logic                  last_beat_s;
  logic                  last_word_s;
  logic                  clear_s;
  logic [DATA_WIDTH-1:0] pack_word_s;
  logic                  pack_full_s;

  // in_ready_r is only ever set in LOAD, so a transfer implies the LOAD state.
  assign beat_fire_s = bus.in_valid && in_ready_r;
  assign last_beat_s = (beat_cnt_r == BEAT_W'(BEATS - 1));
  assign last_word_s = (word_cnt_r == (num_r - CNT_W'(1)));
  assign clear_s     = (state_r == IDLE) && start;

  weight_pack_sreg u_pack (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .load      (beat_fire_s),
    .beat_idx  (beat_cnt_r),
    .beat_data (bus.in_data),
    .word      (pack_word_s),
    .word_full (pack_full_s)
  );

  // Load FSM with counters and registered status/address outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      num_r      <= {CNT_W{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
      beat_cnt_r <= {BEAT_W{1'b0}};
      wr_addr_r  <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            num_r      <= num_words;
            word_cnt_r <= {CNT_W{1'b0}};
            beat_cnt_r <= {BEAT_W{1'b0}};
            busy_r     <= 1'b1;
            if (num_words == {CNT_W{1'b0}}) begin
              state_r    <= DONE;
              in_ready_r <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              state_r    <= LOAD;
              in_ready_r <= 1'b1;
            end
          end else begin
            busy_r     <= 1'b0;
            in_ready_r <= 1'b0;
          end
        end
        LOAD: begin
          if (beat_fire_s) begin
            if (last_beat_s) begin
              beat_cnt_r <= {BEAT_W{1'b0}};
              word_cnt_r <= word_cnt_r + CNT_W'(1);
              wr_addr_r  <= word_cnt_r[ADDR_WIDTH-1:0];
              // Final word: its write strobe lands in the DONE cycle alongside done.
              if (last_word_s) begin
                state_r    <= DONE;
                in_ready_r <= 1'b0;
                done_r     <= 1'b1;
              end else begin
                state_r <= LOAD;
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        DONE: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.wr_en    = pack_full_s;
  assign bus.wr_addr  = wr_addr_r;
  assign bus.wr_data  = pack_word_s;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_weight_b_loader.sv
// Directed bench for weight_b_loader: table of load scenarios plus a mid-load reset sequence.
module tb_weight_b_loader;

  typedef struct {
    int          nwords;
    logic [15:0] base;
    bit          rnd;
    int          restart_at;
    int          exp_done;
    int          exp_busy;
  } load_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] num_words;
  logic       busy;
  logic       done;
  int         vec_cnt = 0;
  int         err_cnt = 0;

  weight_b_loader_if bus();

  weight_b_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".in_ready"}, bus.in_ready, 144'd0);
    check({tag, ".wr_en"},    bus.wr_en,    144'd0);
    check({tag, ".wr_addr"},  bus.wr_addr,  144'd0);
    check({tag, ".wr_data"},  bus.wr_data,  144'd0);
    check({tag, ".busy"},     busy,         144'd0);
    check({tag, ".done"},     done,         144'd0);
  endtask

  // Beat j of a load carries base + j + 1; beat 0 of each word sits in the low 16 bits.
  function automatic logic [143:0] exp_word(input logic [15:0] base, input int w);
    logic [143:0] r;
    r = 144'd0;
    for (int k = 0; k < 9; k++) begin
      r[k*16 +: 16] = base + 16'(w * 9 + k + 1);
    end
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge once busy has dropped.
  task automatic run_load(input load_vec_t v);
    int bj, ws, busy_cyc, done_cnt, done_cyc, budget;
    bit finished;
    bj = 0; ws = 0; busy_cyc = 0; done_cnt = 0; done_cyc = -1; finished = 1'b0;
    budget = 36 * v.nwords + 20;
    start = 1'b1;
    num_words = 9'(v.nwords);
    bus.in_valid = 1'b0;
    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      num_words = 9'(v.nwords);
      if (cyc == 1) check("start_to_ready", bus.in_ready, v.nwords != 0);
      if (bus.wr_en) begin
        check("write_in_range", ws < v.nwords, 1'b1);
        check($sformatf("wr_addr[%0d]", ws), bus.wr_addr, ws[7:0]);
        check($sformatf("wr_data[%0d]", ws), bus.wr_data, exp_word(v.base, ws));
        ws++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_with_last_write", bus.wr_en, v.nwords != 0);
      end
      check("no_ready_outside_load", bus.in_ready && (!busy || done), 1'b0);
      if (busy) busy_cyc++;
      else finished = 1'b1;
      if (!finished) begin
        if (cyc == v.restart_at) begin
          start = 1'b1;
          num_words = 9'd5;
        end
        bus.in_valid = (bj < 9 * v.nwords) && (v.rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
        bus.in_data  = v.base + 16'(bj + 1);
        if (bus.in_valid && bus.in_ready) bj++;
      end
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    check("load_finished", finished, 1'b1);
    check("word_count", ws, v.nwords);
    check("done_pulses", done_cnt, 1);
    if (v.exp_done >= 0) check("done_cycle", done_cyc, v.exp_done);
    if (v.exp_busy >= 0) check("busy_cycles", busy_cyc, v.exp_busy);
  endtask

  initial begin
    load_vec_t vecs[6];
    load_vec_t fresh;
    int bj, nw;

    //         nwords base      rnd  restart exp_done exp_busy
    vecs[0] = '{1,   16'h0000, 1'b0, -1,     10,      10};
    vecs[1] = '{2,   16'h1000, 1'b0, -1,     19,      19};
    vecs[2] = '{2,   16'h1000, 1'b1, -1,     -1,      -1};
    vecs[3] = '{0,   16'h0000, 1'b0, -1,     1,       1};
    vecs[4] = '{3,   16'hA5A0, 1'b0, 14,     28,      28};
    vecs[5] = '{256, 16'h0000, 1'b0, -1,     2305,    2305};
    fresh   = '{1,   16'h3000, 1'b0, -1,     10,      10};

    rst = 1'b0;
    start = 1'b0;
    num_words = 9'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 16'h0000;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    // Beats offered while idle must be refused.
    bus.in_valid = 1'b1;
    bus.in_data = 16'hDEAD;
    @(negedge clk);
    check("idle_no_ready", bus.in_ready, 1'b0);
    check("idle_no_write", bus.wr_en, 1'b0);
    bus.in_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_load(vecs[i]);

    // Reset after beat 4 of word 1 in a two-word load.
    start = 1'b1;
    num_words = 9'd2;
    @(negedge clk);
    start = 1'b0;
    bj = 0;
    nw = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.wr_en) nw++;
      if (bj == 14) break;
      bus.in_valid = 1'b1;
      bus.in_data = 16'h2000 + 16'(bj + 1);
      if (bus.in_ready) bj++;
      @(negedge clk);
    end
    check("midload_beats", bj, 14);
    check("midload_writes_before_rst", nw, 1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset("midload_reset");
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_reset_no_write", bus.wr_en, 1'b0);
      check("post_reset_idle", busy, 1'b0);
    end
    run_load(fresh);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
